// File: rtl/aes_hmac_pkg.sv
// Shared types and constants for the AES/HMAC result path.
package aes_hmac_pkg;

    localparam int BURST_BYTES = 16;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SHORT   = 2'b01;
    localparam logic [1:0] ERR_LONG    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        WAIT_CT = 3'd0,
        RX_CT   = 3'd1,
        GAP     = 3'd2,
        RX_MAC  = 3'd3,
        DONE    = 3'd4
    } collector_state_e;

endpackage

// File: rtl/aes_hmac_result_collector_if.sv
// Byte-stream input and result/host handshake of the result collector.
// Optional RESULT_MAC_CHECK_EN adds i_exp_mac / o_mac_ok.
interface aes_hmac_result_collector_if;
    // i_data is consumed on every clock where i_valid=1 (no backpressure);
    // o_done is a level held until the host pulses i_ack, and i_ack has no
    // effect while o_done=0; o_cipher/o_mac are stable whenever o_done=1.
    logic [7:0]   i_data;
    logic         i_valid;
    logic [127:0] o_cipher;
    logic [127:0] o_mac;
    logic         o_done;
    logic         i_ack;
    logic         o_err;
    logic [1:0]   o_err_code;
`ifdef RESULT_MAC_CHECK_EN
    logic [127:0] i_exp_mac;
    logic         o_mac_ok;

    modport slave (
        input  i_data, i_valid, i_ack, i_exp_mac,
        output o_cipher, o_mac, o_done, o_err, o_err_code, o_mac_ok
    );
    modport master (
        output i_data, i_valid, i_ack, i_exp_mac,
        input  o_cipher, o_mac, o_done, o_err, o_err_code, o_mac_ok
    );
`else
    modport slave (
        input  i_data, i_valid, i_ack,
        output o_cipher, o_mac, o_done, o_err, o_err_code
    );
    modport master (
        output i_data, i_valid, i_ack,
        input  o_cipher, o_mac, o_done, o_err, o_err_code
    );
`endif
endinterface

// File: rtl/aes_hmac_result_collector_deser.sv
// Byte-to-word deserialiser shared by the ciphertext and MAC bursts,
// with short-burst and overlong-burst detection.
module byte_burst_deser #(
    parameter int BURST_BYTES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     en_i,
    input  logic [7:0]               i_data,
    input  logic                     i_valid,
    output logic [8*BURST_BYTES-1:0] word_o,
    output logic                     word_valid_o,
    output logic                     err_short_o,
    output logic                     err_long_o
);
    localparam logic [4:0] LAST = 5'(BURST_BYTES - 1);
    localparam logic [4:0] FULL = 5'(BURST_BYTES);

    logic [8*(BURST_BYTES-1)-1:0] word_q;
    logic [4:0]                   cnt_q;
    logic                         full_q;

    // The final byte is merged combinationally so the parent can register
    // the complete word in the same cycle that byte arrives.
    assign word_o       = {i_data, word_q};
    assign word_valid_o = en_i && i_valid && (cnt_q == LAST);
    assign err_short_o  = en_i && !i_valid && (cnt_q < FULL);
    assign err_long_o   = full_q && i_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= 5'd0;
            full_q <= 1'b0;
        end else begin
            full_q <= word_valid_o;
            if (start_i) begin
                word_q[7:0] <= i_data;
                cnt_q       <= 5'd1;
            end else if (en_i && i_valid && (cnt_q < FULL)) begin
                if (cnt_q < LAST) begin
                    word_q[8*cnt_q +: 8] <= i_data;
                end
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end
endmodule

// File: rtl/aes_hmac_result_collector.sv
// Collects the ciphertext+MAC byte bursts into 128-bit words for the host.
// RESULT_MAC_CHECK_EN enables the expected-MAC comparison output.
module aes_hmac_result_collector #(
    parameter int BURST_BYTES    = aes_hmac_pkg::BURST_BYTES,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 12
) (
    input  logic                            clk,
    input  logic                            rst_n,
    aes_hmac_result_collector_if.slave      bus,
    output aes_hmac_pkg::collector_state_e  o_state
);
    import aes_hmac_pkg::*;

    localparam int              W       = 8 * BURST_BYTES;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    collector_state_e state_q;
    logic             drain_q;
    logic [TO_W-1:0]  to_q;
    logic [W-1:0]     ct_buf_q;
    logic [W-1:0]     cipher_q;
    logic [W-1:0]     mac_q;
    logic             done_q;
    logic             err_q;
    logic [1:0]       err_code_q;
`ifdef RESULT_MAC_CHECK_EN
    logic             mac_ok_q;
`endif

    logic         start;
    logic         en;
    logic [W-1:0] word;
    logic         word_valid;
    logic         err_short;
    logic         err_long;

    // A new burst may start from idle, from the gap (MAC byte 0), or on the
    // acknowledging cycle; an overlong run in progress never starts one.
    assign start = ((state_q == WAIT_CT) && bus.i_valid && !drain_q) ||
                   ((state_q == GAP) && bus.i_valid && !err_long) ||
                   ((state_q == DONE) && bus.i_ack && bus.i_valid &&
                    !err_long && !drain_q);
    assign en    = (state_q == RX_CT) || (state_q == RX_MAC);

    byte_burst_deser #(.BURST_BYTES(BURST_BYTES)) u_deser (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .en_i         (en),
        .i_data       (bus.i_data),
        .i_valid      (bus.i_valid),
        .word_o       (word),
        .word_valid_o (word_valid),
        .err_short_o  (err_short),
        .err_long_o   (err_long)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= WAIT_CT;
            drain_q    <= 1'b0;
            to_q       <= '0;
            ct_buf_q   <= '0;
            cipher_q   <= '0;
            mac_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
`ifdef RESULT_MAC_CHECK_EN
            mac_ok_q   <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
            if (!bus.i_valid) drain_q <= 1'b0;
            unique case (state_q)
                WAIT_CT: if (start) state_q <= RX_CT;
                RX_CT: begin
                    if (err_short) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_SHORT;
                        state_q    <= WAIT_CT;
                    end else if (word_valid) begin
                        ct_buf_q <= word;
                        to_q     <= '0;
                        state_q  <= GAP;
                    end
                end
                GAP: begin
                    if (err_long) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_LONG;
                        drain_q    <= 1'b1;
                        state_q    <= WAIT_CT;
                    end else if (bus.i_valid) begin
                        state_q <= RX_MAC;
                    end else begin
                        if (to_q != '1) to_q <= to_q + 1'b1;
                        if ((TIMEOUT_CYCLES != 0) && (to_q == TO_LAST)) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_TIMEOUT;
                            state_q    <= WAIT_CT;
                        end
                    end
                end
                RX_MAC: begin
                    if (err_short) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_SHORT;
                        state_q    <= WAIT_CT;
                    end else if (word_valid) begin
                        cipher_q <= ct_buf_q;
                        mac_q    <= word;
                        done_q   <= 1'b1;
`ifdef RESULT_MAC_CHECK_EN
                        mac_ok_q <= (word == bus.i_exp_mac);
`endif
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    // An overlong MAC burst is reported but the result stands.
                    if (err_long) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_LONG;
                        drain_q    <= 1'b1;
                    end
                    if (bus.i_ack) begin
                        done_q  <= 1'b0;
`ifdef RESULT_MAC_CHECK_EN
                        mac_ok_q <= 1'b0;
`endif
                        state_q <= start ? RX_CT : WAIT_CT;
                    end
                end
                default: state_q <= WAIT_CT;
            endcase
        end
    end

    assign bus.o_cipher   = cipher_q;
    assign bus.o_mac      = mac_q;
    assign bus.o_done     = done_q;
    assign bus.o_err      = err_q;
    assign bus.o_err_code = err_code_q;
`ifdef RESULT_MAC_CHECK_EN
    assign bus.o_mac_ok   = mac_ok_q;
`endif
    assign o_state        = state_q;
endmodule

// File: tb/tb_aes_hmac_result_collector.sv
// Directed bench for aes_hmac_result_collector with a queue-based scoreboard.
// Build with +define+RESULT_MAC_CHECK_EN to also cover o_mac_ok.
module tb_aes_hmac_result_collector;
    import aes_hmac_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    aes_hmac_result_collector_if bus ();
    collector_state_e state;

    aes_hmac_result_collector #(.TIMEOUT_CYCLES(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .o_state (state)
    );

    typedef struct {
        logic [127:0] cipher;
        logic [127:0] mac;
        logic         mac_ok;
        int           cyc;
    } res_t;

    res_t         res_q[$];
    logic [1:0]   exp_q[$];
    int           exp_cyc_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_data  = base + 8'(i);
            bus.i_valid = 1'b1;
            step();
        end
    endtask

    task automatic idle(input int n);
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        repeat (n) step();
    endtask

    function automatic logic [127:0] make_word(input logic [7:0] base);
        logic [127:0] w;
        for (int k = 0; k < 16; k++) w[8*k +: 8] = base + 8'(k);
        return w;
    endfunction

    task automatic push_res(input logic [127:0] c, input logic [127:0] m);
        logic ok;
        ok = 1'b0;
`ifdef RESULT_MAC_CHECK_EN
        ok = (m == bus.i_exp_mac);
`endif
        res_q.push_back('{cipher: c, mac: m, mac_ok: ok, cyc: cyc});
    endtask

    task automatic push_err(input logic [1:0] code, input int at_cyc);
        exp_q.push_back(code);
        exp_cyc_q.push_back(at_cyc);
    endtask

    task automatic send_pair(input logic [7:0] ct_base, input logic [7:0] mac_base, input int gap);
        send_bytes(ct_base, 16);
        idle(gap);
        send_bytes(mac_base, 16);
        bus.i_valid = 1'b0;
        push_res(make_word(ct_base), make_word(mac_base));
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (bus.o_done !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("done_seen", 128'(bus.o_done), 128'(1));
        bus.i_ack = 1'b1;
        step();
        bus.i_ack = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cipher"}, bus.o_cipher, 128'h0);
        check({tag, "_mac"}, bus.o_mac, 128'h0);
        check({tag, "_done"}, 128'(bus.o_done), 128'h0);
        check({tag, "_err"}, 128'(bus.o_err), 128'h0);
        check({tag, "_err_code"}, 128'(bus.o_err_code), 128'(ERR_NONE));
        check({tag, "_state"}, 128'(state), 128'(WAIT_CT));
`ifdef RESULT_MAC_CHECK_EN
        check({tag, "_mac_ok"}, 128'(bus.o_mac_ok), 128'h0);
`endif
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        res_t         cur;
        logic         have_cur;
        logic         prev_done;
        logic [1:0]   ecode;
        int           ecyc;
        have_cur  = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_done = 1'b0;
                have_cur  = 1'b0;
            end else begin
                if (bus.o_done === 1'b1 && prev_done !== 1'b1) begin
                    if (res_q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL unexpected_done: got o_done=1 at cycle %0d, expected no pending result", cyc);
                        have_cur = 1'b0;
                    end else begin
                        cur = res_q.pop_front();
                        have_cur = 1'b1;
                        check("cipher", bus.o_cipher, cur.cipher);
                        check("mac", bus.o_mac, cur.mac);
                        check("done_latency", 128'(cyc), 128'(cur.cyc));
`ifdef RESULT_MAC_CHECK_EN
                        check("mac_ok", 128'(bus.o_mac_ok), 128'(cur.mac_ok));
`endif
                    end
                end else if (bus.o_done === 1'b1 && have_cur) begin
                    check("cipher_hold", bus.o_cipher, cur.cipher);
                    check("mac_hold", bus.o_mac, cur.mac);
                end
                prev_done = bus.o_done;
                if (bus.o_err === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL unexpected_err: got code %0b at cycle %0d, expected no error", bus.o_err_code, cyc);
                    end else begin
                        ecode = exp_q.pop_front();
                        ecyc  = exp_cyc_q.pop_front();
                        check("err_code", 128'(bus.o_err_code), 128'(ecode));
                        if (ecyc >= 0) check("err_cycle", 128'(cyc), 128'(ecyc));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] hs_ct;
        bus.i_data  = 8'h00;
        bus.i_valid = 1'b0;
        bus.i_ack   = 1'b0;
`ifdef RESULT_MAC_CHECK_EN
        bus.i_exp_mac = 128'h0;
`endif
        rst_n = 1'b0;
        idle(3);
        check_reset_state("reset");
        rst_n = 1'b1;
        idle(2);

        // Nominal pair with hand-computed words
`ifdef RESULT_MAC_CHECK_EN
        bus.i_exp_mac = 128'h1F1E1D1C1B1A19181716151413121110;
`endif
        send_bytes(8'h00, 16);
        idle(5);
        send_bytes(8'h10, 16);
        bus.i_valid = 1'b0;
        push_res(128'h0F0E0D0C0B0A09080706050403020100,
                 128'h1F1E1D1C1B1A19181716151413121110);
        wait_ack();
        idle(2);

        // Short ciphertext burst, then a good pair
        send_bytes(8'h55, 10);
        push_err(ERR_SHORT, cyc + 1);
        idle(3);
        send_pair(8'h20, 8'h30, 4);
        wait_ack();
        idle(2);

        // Overlong burst: 17 bytes plus 2 more while i_valid stays high
        push_err(ERR_LONG, cyc + 17);
        send_bytes(8'h40, 19);
        idle(3);
        check("long_state", 128'(state), 128'(WAIT_CT));
        send_pair(8'h50, 8'h60, 2);
        wait_ack();
        idle(2);

        // MAC timeout: o_err exactly 8 cycles after last ciphertext byte
        send_bytes(8'h70, 16);
        bus.i_valid = 1'b0;
        push_err(ERR_TIMEOUT, cyc + 8);
        idle(12);
        check("timeout_state", 128'(state), 128'(WAIT_CT));
        check("timeout_done", 128'(bus.o_done), 128'h0);
        check("err_code_held", 128'(bus.o_err_code), 128'(ERR_TIMEOUT));

        // Handshake: junk while unacknowledged, then ack with a new byte 0
`ifdef RESULT_MAC_CHECK_EN
        bus.i_exp_mac = make_word(8'h90) ^ 128'h1;
`endif
        send_pair(8'h80, 8'h90, 3);
        idle(1);
        for (int i = 0; i < 20; i++) begin
            bus.i_data  = 8'($urandom_range(0, 255));
            bus.i_valid = 1'b1;
            step();
        end
        bus.i_ack   = 1'b1;
        bus.i_data  = 8'hAA;
        bus.i_valid = 1'b1;
        step();
        bus.i_ack   = 1'b0;
        send_bytes(8'hA1, 15);
        idle(2);
        send_bytes(8'hC0, 16);
        bus.i_valid = 1'b0;
        hs_ct = make_word(8'hA0);
        hs_ct[7:0] = 8'hAA;
        push_res(hs_ct, make_word(8'hC0));
        wait_ack();
        idle(2);

        // Reset in the middle of the MAC burst
        send_bytes(8'hD0, 16);
        idle(2);
        send_bytes(8'hE0, 7);
        bus.i_valid = 1'b0;
        rst_n = 1'b0;
        step();
        check_reset_state("midreset");
        rst_n = 1'b1;
        idle(2);
`ifdef RESULT_MAC_CHECK_EN
        bus.i_exp_mac = make_word(8'h01);
`endif
        send_pair(8'hF0, 8'h01, 2);
        wait_ack();
        idle(5);

        check("res_q_drained", 128'(res_q.size()), 128'h0);
        check("err_q_drained", 128'(exp_q.size()), 128'h0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        chk_cnt++;
        $display("FAIL watchdog: got no completion by %0t, expected bench end", $time);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/aes_hmac_result_collector.md
Name: aes_hmac_result_collector

Overview:
- Downstream consumer of the AES/HMAC top's byte-serial result stream (o_data/o_valid).
- The top emits two contiguous 16-byte bursts per transaction: ciphertext, then the MAC. Each burst is sent least-significant byte first.
- This block deserialises both bursts into 128-bit words, holds them for a host-side valid/ack handshake, and flags malformed bursts and MAC timeouts.

Parameters:
- BURST_BYTES, 16, bytes per burst; fixed 16 for 128-bit outputs; other values unsupported.
- TIMEOUT_CYCLES, 4096, max idle cycles between end of ciphertext burst and first MAC byte; 0 disables timeout.
- TO_W, 12, width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_data  in  8  result byte from AES/HMAC top
- i_valid  in  1  i_data valid; bursts are contiguous valid-high runs
- o_cipher  out  128  captured ciphertext; byte k of burst at bits [8k+7:8k]
- o_mac  out  128  captured MAC, same byte ordering
- o_done  out  1  result pair valid; held until i_ack
- i_ack  in  1  host consumed result; sampled only while o_done=1
- o_err  out  1  one-cycle error pulse
- o_err_code  out  2  01 short burst, 10 long burst, 11 MAC timeout; held until next error or reset

Behaviour:
- Reset (synchronous, rst_n=0 at posedge clk): state WAIT_CT; byte/timeout counters 0; internal ct_buf 0; o_cipher=0; o_mac=0; o_done=0; o_err=0; o_err_code=00. Reset mid-burst discards partial data.
- States: WAIT_CT, RX_CT, GAP, RX_MAC, DONE.
- WAIT_CT: when i_valid=1, write the byte to ct_buf[7:0], set cnt=1, go to RX_CT.
- RX_CT, cycle with i_valid=1 and cnt<16: write the byte to ct_buf[8*cnt+:8], then cnt++.
- RX_CT, i_valid=0 with cnt<16: assert o_err with code 01, go to WAIT_CT.
- RX_CT, cnt reaches 16: go to GAP and clear the timeout counter.
- GAP, cycle entered with i_valid still high (17th contiguous byte): assert o_err with code 10, go to WAIT_CT. That byte is dropped, and bytes remain dropped until i_valid falls. A "drain" flag in WAIT_CT blocks restart while i_valid stays high.
- GAP, i_valid=0: increment the timeout counter. If TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES, assert o_err with code 11 and go to WAIT_CT.
- GAP, later i_valid=1: capture the byte into mac_buf[7:0], set cnt=1, go to RX_MAC.
- RX_MAC: same rules as RX_CT, with identical short/long-burst checks. The long check happens in the cycle after the 16th byte.
- RX_MAC completion: on the 16th byte, o_cipher<=ct_buf, o_mac<={byte,mac_buf[119:0]}, o_done<=1, go to DONE.
  - Latency: o_done rises the cycle after the last MAC byte.
  - A 17th contiguous MAC byte in the next cycle asserts o_err with code 10, but o_done/outputs are kept (error is advisory).
- DONE: i_valid is ignored except as noted below. o_cipher/o_mac are stable.
  - i_ack=1: o_done<=0 and go to WAIT_CT.
  - i_ack=1 together with i_valid=1 in the same cycle: that byte is taken as ciphertext byte 0 (go to RX_CT, cnt=1).
- i_ack while o_done=0: ignored.
- o_err is high for exactly one cycle per error event. Error events return to WAIT_CT (drain rule applies).
- Counters: cnt is 5 bits, compared against 16, and never wraps. The timeout counter saturates.

Optional Feature:
- Macro: RESULT_MAC_CHECK_EN.
- Defined: adds ports i_exp_mac (in, 128) and o_mac_ok (out, 1). o_mac_ok is registered alongside o_done as (captured mac == i_exp_mac), sampled in the completion cycle. It is held with o_done and cleared on ack or reset.
- Undefined: neither port exists; no comparator logic.

Decomposition:
- Shared package aes_hmac_pkg:
  - state enum for this block
  - ERR_SHORT=2'b01, ERR_LONG=2'b10, ERR_TIMEOUT=2'b11
  - BURST_BYTES default constant
- One natural sub-module: byte_burst_deser. It is instantiated once and reused for both bursts. Functions:
  - byte-to-word assembly
  - cnt handling
  - short/long detection
  - outputs: word, word_valid, err_short, err_long
- The FSM and timeout stay in the parent.

Test Plan:
- Nominal: ciphertext bytes 0x00..0x0F, 5 idle cycles, MAC bytes 0x10..0x1F.
  - Expect o_done one cycle after the last byte.
  - Expect o_cipher=0x0F0E..0100 and o_mac=0x1F1E..1110.
  - Expect o_err never asserted.
- Short burst: 10 ciphertext bytes, then i_valid low.
  - Expect o_err pulse with code 01 on the first low cycle.
  - A following full pair still completes correctly.
- Long burst: 17 contiguous ciphertext bytes.
  - Expect o_err with code 10 at byte 17; nothing captured.
  - The next pair after i_valid drops completes normally.
- Timeout: TIMEOUT_CYCLES=8, full ciphertext burst, no MAC.
  - Expect o_err with code 11 exactly 8 cycles after the last ciphertext byte; o_done stays 0.
- Handshake: hold i_ack=0 for 20 cycles after o_done while sending junk valid bytes.
  - Expect outputs unchanged.
  - Then i_ack=1 with i_valid=1 and data 0xAA: the next pair yields o_cipher[7:0]=0xAA.
- Reset mid-MAC-burst at byte 7.
  - Expect all outputs 0 and state WAIT_CT.
  - A fresh pair then completes.
  - With RESULT_MAC_CHECK_EN: o_mac_ok=1 for a matching i_exp_mac and 0 for one flipped bit.
